// File: rtl/cpu_sequencer.sv
// Multi-cycle control sequencer for the 8-bit, 4-register CPU datapath.
// Walks FETCH/DECODE/READ/EXEC/WRITE and owns the PC, fetch handshake, halt and fault state.
module cpu_sequencer #(
  parameter int unsigned PC_W      = 4,
  parameter int unsigned FETCH_TMO = 15
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            step_mode,
  input  logic            halt_req,
  input  logic            imem_ack,
  input  logic [7:0]      imem_data,
  output logic [PC_W-1:0] pc,
  output logic            imem_req,
  output logic [1:0]      op,
  output logic [1:0]      src1_addr,
  output logic [1:0]      src2_addr,
  output logic [1:0]      dest_addr,
  output logic            rd_en,
  output logic            alu_en,
  output logic            wr_en,
  output logic            busy,
  output logic            halted,
  output logic            fault,
  output logic [7:0]      retired
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_READ,
    S_EXEC,
    S_WRITE
  } state_t;

  // Counter value on the last allowed FETCH cycle without an ack.
  localparam logic [7:0] TMO_LAST = 8'(FETCH_TMO - 1);

  state_t      state;
  state_t      state_nx;
  logic [7:0]  ir;
  logic [7:0]  tmo_cnt;
  logic        halt_flag;
  logic        tmo_hit;
  logic        halt_now;
  logic        launch;

  logic        imem_req_d;
  logic        rd_en_d;
  logic        alu_en_d;
  logic        wr_en_d;
  logic        busy_d;

  assign tmo_hit  = (state == S_FETCH) && !imem_ack && (tmo_cnt == TMO_LAST);
  // A halt request arriving in WRITE itself still stops at this boundary.
  assign halt_now = halt_flag || halt_req;
  assign launch   = (state == S_IDLE) && start && !fault;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      imem_req <= 1'b0;
      rd_en    <= 1'b0;
      alu_en   <= 1'b0;
      wr_en    <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_nx;
      imem_req <= imem_req_d;
      rd_en    <= rd_en_d;
      alu_en   <= alu_en_d;
      wr_en    <= wr_en_d;
      busy     <= busy_d;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: begin
        if (start && !fault) state_nx = S_FETCH;
      end
      S_FETCH: begin
        if (imem_ack)     state_nx = S_DECODE;
        else if (tmo_hit) state_nx = S_IDLE;
      end
      S_DECODE: state_nx = S_READ;
      S_READ:   state_nx = S_EXEC;
      S_EXEC:   state_nx = S_WRITE;
      S_WRITE: begin
        if (halt_now || step_mode) state_nx = S_IDLE;
        else                       state_nx = S_FETCH;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Strobes are decoded from the next state so they leave the flops aligned with the state.
  always_comb begin
    imem_req_d = (state_nx == S_FETCH);
    rd_en_d    = (state_nx == S_READ);
    alu_en_d   = (state_nx == S_EXEC);
    wr_en_d    = (state_nx == S_WRITE);
    busy_d     = (state_nx != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc        <= '0;
      ir        <= '0;
      tmo_cnt   <= '0;
      halt_flag <= 1'b0;
      halted    <= 1'b0;
      fault     <= 1'b0;
      retired   <= '0;
      op        <= '0;
      src1_addr <= '0;
      src2_addr <= '0;
      dest_addr <= '0;
    end else begin
      // Counter is held at zero outside FETCH, so it is clear on every FETCH entry.
      if (state != S_FETCH)  tmo_cnt <= '0;
      else if (!imem_ack)    tmo_cnt <= tmo_cnt + 8'd1;

      if (state == S_FETCH && imem_ack) begin
        ir <= imem_data;
        pc <= pc + PC_W'(1);
      end

      if (tmo_hit) fault <= 1'b1;

      if (state == S_DECODE) begin
        op        <= ir[7:6];
        dest_addr <= ir[5:4];
        src1_addr <= ir[3:2];
        src2_addr <= ir[1:0];
      end

      if (launch)                                halt_flag <= 1'b0;
      else if (state != S_IDLE && halt_req)      halt_flag <= 1'b1;

      if (launch)                                halted <= 1'b0;
      else if (state == S_WRITE && halt_now)     halted <= 1'b1;

      if (state == S_WRITE && retired != 8'hFF)  retired <= retired + 8'd1;
    end
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: instruction-level reference model plus directed literal checks.
module tb_cpu_sequencer;
  localparam int unsigned PC_W = 4;
  localparam int unsigned TMO  = 15;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            start = 1'b0;
  logic            step_mode = 1'b0;
  logic            halt_req = 1'b0;
  logic            imem_ack = 1'b0;
  logic [7:0]      imem_data = '0;
  logic [PC_W-1:0] pc;
  logic            imem_req;
  logic [1:0]      op, src1_addr, src2_addr, dest_addr;
  logic            rd_en, alu_en, wr_en, busy, halted, fault;
  logic [7:0]      retired;

  cpu_sequencer #(.PC_W(PC_W), .FETCH_TMO(TMO)) dut (
    .clk(clk), .reset(reset), .start(start), .step_mode(step_mode),
    .halt_req(halt_req), .imem_ack(imem_ack), .imem_data(imem_data),
    .pc(pc), .imem_req(imem_req), .op(op), .src1_addr(src1_addr),
    .src2_addr(src2_addr), .dest_addr(dest_addr), .rd_en(rd_en),
    .alu_en(alu_en), .wr_en(wr_en), .busy(busy), .halted(halted),
    .fault(fault), .retired(retired)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Model: m_post counts cycles since the fetch was accepted (0 = still fetching).
  bit m_run, m_fault, m_halted, m_hflag;
  int m_post, m_wait, m_pc, m_ret, m_ir;
  int m_op, m_s1, m_s2, m_d;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d, t=%0t)", name, act, exp, cyc, $time);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_fault = 0; m_halted = 0; m_hflag = 0;
    m_post = 0; m_wait = 0; m_pc = 0; m_ret = 0; m_ir = 0;
    m_op = 0; m_s1 = 0; m_s2 = 0; m_d = 0;
  endtask

  task automatic model_step();
    bit hnow;
    if (!m_run) begin
      if (start && !m_fault) begin
        m_run = 1; m_post = 0; m_wait = 0; m_halted = 0; m_hflag = 0;
      end
    end else begin
      hnow = m_hflag || halt_req;
      if (halt_req) m_hflag = 1;
      case (m_post)
        0: begin
          if (imem_ack) begin
            m_ir = int'(imem_data);
            m_pc = (m_pc + 1) % (1 << PC_W);
            m_post = 1;
          end else begin
            m_wait++;
            if (m_wait == TMO) begin m_fault = 1; m_run = 0; end
          end
        end
        1: begin
          m_op = (m_ir >> 6) & 3; m_d = (m_ir >> 4) & 3;
          m_s1 = (m_ir >> 2) & 3; m_s2 = m_ir & 3;
          m_post = 2;
        end
        2: m_post = 3;
        3: m_post = 4;
        default: begin
          if (m_ret < 255) m_ret++;
          if (hnow) begin m_run = 0; m_halted = 1; end
          else if (step_mode) m_run = 0;
          else begin m_post = 0; m_wait = 0; end
        end
      endcase
    end
  endtask

  task automatic compare_all();
    check("busy",      busy,      m_run);
    check("imem_req",  imem_req,  m_run && m_post == 0);
    check("rd_en",     rd_en,     m_run && m_post == 2);
    check("alu_en",    alu_en,    m_run && m_post == 3);
    check("wr_en",     wr_en,     m_run && m_post == 4);
    check("pc",        pc,        m_pc);
    check("retired",   retired,   m_ret);
    check("fault",     fault,     m_fault);
    check("halted",    halted,    m_halted);
    check("op",        op,        m_op);
    check("dest_addr", dest_addr, m_d);
    check("src1_addr", src1_addr, m_s1);
    check("src2_addr", src2_addr, m_s2);
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    if (!reset) model_reset();
    else        model_step();
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    start = 0; step_mode = 0; halt_req = 0; imem_ack = 0; imem_data = '0;
    reset = 0;
    #1;
    model_reset();
    compare_all();
    tick();
    tick();
    reset = 1;
    cyc = 0;
  endtask

  initial begin
    int wr_mask;
    int idle_cnt;
    bit saw_wrap;
    logic [PC_W-1:0] prev_pc;

    model_reset();
    #2;
    do_reset();
    check("reset pc literal", pc, 0);
    check("reset busy literal", busy, 0);

    // Back-to-back instructions, ack on the first FETCH cycle.
    start = 1; imem_ack = 1; imem_data = 8'h6D;
    wr_mask = 0;
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (wr_en) wr_mask |= (1 << i);
    end
    check("wr_en cycles", wr_mask, (1 << 5) | (1 << 10) | (1 << 15));
    check("retired after 3", retired, 3);
    check("pc after 3", pc, 3);

    // Field decode.
    do_reset();
    start = 1; imem_ack = 1; imem_data = 8'b01_10_00_11;
    repeat (3) tick();
    check("decode op", op, 1);
    check("decode dest", dest_addr, 2);
    check("decode src1", src1_addr, 0);
    check("decode src2", src2_addr, 3);
    check("rd_en in READ", rd_en, 1);
    tick();
    check("alu_en in EXEC", {rd_en, alu_en, wr_en}, 3'b010);
    tick();
    check("wr_en in WRITE", {rd_en, alu_en, wr_en}, 3'b001);

    // Single-step with start held.
    do_reset();
    step_mode = 1; start = 1; imem_ack = 1; imem_data = 8'h1B;
    idle_cnt = 0;
    repeat (18) begin
      tick();
      if (!busy) idle_cnt++;
    end
    check("step idle cycles", idle_cnt, 3);
    check("step retired", retired, 3);
    step_mode = 0;

    // Halt requested during EXEC.
    do_reset();
    start = 1; imem_ack = 1; imem_data = 8'hC4;
    tick();
    start = 0;
    repeat (3) tick();
    halt_req = 1;
    tick();
    halt_req = 0;
    tick();
    check("halt halted", halted, 1);
    check("halt busy", busy, 0);
    check("halt pc", pc, 1);
    start = 1;
    tick();
    check("resume halted", halted, 0);
    check("resume busy", busy, 1);

    // Fetch timeout.
    do_reset();
    start = 1; imem_ack = 0;
    repeat (15) tick();
    check("tmo fault before", fault, 0);
    check("tmo busy before", busy, 1);
    tick();
    check("tmo fault", fault, 1);
    check("tmo busy", busy, 0);
    imem_ack = 1;
    repeat (5) tick();
    check("tmo start ignored", busy, 0);

    // Asynchronous reset while in READ.
    do_reset();
    start = 1; imem_ack = 1; imem_data = 8'hA5;
    repeat (3) tick();
    check("pre-reset rd_en", rd_en, 1);
    start = 0;
    #2 reset = 0;
    #1;
    model_reset();
    check("async rd_en", rd_en, 0);
    check("async pc", pc, 0);
    compare_all();
    tick();
    reset = 1;
    repeat (6) tick();

    // 300 instructions: pc wrap and retired saturation.
    do_reset();
    start = 1; imem_ack = 1;
    saw_wrap = 0;
    prev_pc = pc;
    repeat (1510) begin
      imem_data = 8'($urandom);
      tick();
      if (prev_pc == 4'd15 && pc == 4'd0) saw_wrap = 1;
      prev_pc = pc;
    end
    check("pc wrapped", saw_wrap, 1);
    check("retired saturated", retired, 255);

    // Randomized traffic.
    do_reset();
    repeat (6000) begin
      start     = ($urandom_range(0, 3) != 0);
      step_mode = ($urandom_range(0, 4) == 0);
      halt_req  = ($urandom_range(0, 19) == 0);
      imem_ack  = ($urandom_range(0, 9) < 6);
      imem_data = 8'($urandom);
      if ($urandom_range(0, 299) == 0) reset = 0;
      else                             reset = 1;
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
